// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall control path:
// FSM state encoding, the x0 register address and the RAW-match helper.
package hazard_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_e;

  localparam logic [31:0] REG_X0 = '0;

  // True when a producer writing rd feeds an operand rs that is actually read.
  // Widened to 32 bits so any register-address width can share it.
  function automatic logic is_rd_hazard(input logic [31:0] rd,
                                        input logic [31:0] rs,
                                        input logic        used);
    return used && (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating event counter with enable; holds at all-ones once reached.
module stall_perf_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stalls,
// multi-cycle multiply freeze, taken-branch squash and a stall-cycle counter.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  input  logic                  mul_start_ex,
  input  logic                  branch_taken_ex,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  id_ex_enable,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  mul_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [7:0] MUL_CNT_INIT = 8'(MUL_LATENCY - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] mul_cnt_q, mul_cnt_d;
  logic       load_use;

  assign load_use = mem_read_ex &&
                    (is_rd_hazard(32'(rd_ex), 32'(rs1_id), rs1_used_id) ||
                     is_rd_hazard(32'(rd_ex), 32'(rs2_id), rs2_used_id));

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mul_busy     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mul_start_ex && (MUL_LATENCY > 1)) begin
          mul_busy     = 1'b1;
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          flush_ex_mem = 1'b1;
          state_d      = MUL_BUSY;
          mul_cnt_d    = MUL_CNT_INIT;
        end else if (branch_taken_ex) begin
          // The load-use victim sits in ID and is squashed, so no stall.
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          flush_id_ex  = 1'b1;
        end
      end
      MUL_BUSY: begin
        mul_busy = 1'b1;
        if (mul_cnt_q > 8'd1) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          flush_ex_mem = 1'b1;
          mul_cnt_d    = mul_cnt_q - 8'd1;
        end else begin
          state_d   = IDLE;
          mul_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        mul_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  stall_perf_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .en    (!pc_enable),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: default instance, a CNT_W=4 instance for saturation and a
// MUL_LATENCY=1 instance, all driven from the same ID/EX stimulus.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       rs1_used_id, rs2_used_id, mem_read_ex, mul_start_ex, branch_taken_ex;

  logic        a_pc, a_ifid, a_idex, a_fif, a_fidex, a_fexm, a_busy;
  logic [15:0] a_cnt;
  logic        s_pc, s_ifid, s_idex, s_fif, s_fidex, s_fexm, s_busy;
  logic [3:0]  s_cnt;
  logic        o_pc, o_ifid, o_idex, o_fif, o_fidex, o_fexm, o_busy;
  logic [15:0] o_cnt;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Bit order: pc, if_id, id_ex, flush_if_id, flush_id_ex, flush_ex_mem, mul_busy
  localparam logic [6:0] O_DEF = 7'b1110000;
  localparam logic [6:0] O_LU  = 7'b0010100;
  localparam logic [6:0] O_BR  = 7'b1111100;
  localparam logic [6:0] O_FRZ = 7'b0000011;
  localparam logic [6:0] O_REL = 7'b1110001;

  always #5 clk = ~clk;

  pipeline_hazard_controller u_a (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .mul_start_ex(mul_start_ex),
    .branch_taken_ex(branch_taken_ex), .pc_enable(a_pc), .if_id_enable(a_ifid),
    .id_ex_enable(a_idex), .flush_if_id(a_fif), .flush_id_ex(a_fidex),
    .flush_ex_mem(a_fexm), .mul_busy(a_busy), .stall_count(a_cnt)
  );

  pipeline_hazard_controller #(.CNT_W(4)) u_s (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .mul_start_ex(mul_start_ex),
    .branch_taken_ex(branch_taken_ex), .pc_enable(s_pc), .if_id_enable(s_ifid),
    .id_ex_enable(s_idex), .flush_if_id(s_fif), .flush_id_ex(s_fidex),
    .flush_ex_mem(s_fexm), .mul_busy(s_busy), .stall_count(s_cnt)
  );

  pipeline_hazard_controller #(.MUL_LATENCY(1)) u_o (
    .clk(clk), .arst_n(arst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex), .mul_start_ex(mul_start_ex),
    .branch_taken_ex(branch_taken_ex), .pc_enable(o_pc), .if_id_enable(o_ifid),
    .id_ex_enable(o_idex), .flush_if_id(o_fif), .flush_id_ex(o_fidex),
    .flush_ex_mem(o_fexm), .mul_busy(o_busy), .stall_count(o_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outs(input string tag, input logic [6:0] ea, input logic [6:0] eo);
    chk({tag, "_a"}, 32'({a_pc, a_ifid, a_idex, a_fif, a_fidex, a_fexm, a_busy}), 32'(ea));
    chk({tag, "_s"}, 32'({s_pc, s_ifid, s_idex, s_fif, s_fidex, s_fexm, s_busy}), 32'(ea));
    chk({tag, "_o"}, 32'({o_pc, o_ifid, o_idex, o_fif, o_fidex, o_fexm, o_busy}), 32'(eo));
  endtask

  task automatic chk_cnt(input string tag, input int unsigned ea, input int unsigned es,
                         input int unsigned eo);
    chk({tag, "_cnt_a"}, 32'(a_cnt), ea);
    chk({tag, "_cnt_s"}, 32'(s_cnt), es);
    chk({tag, "_cnt_o"}, 32'(o_cnt), eo);
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic u1, input logic [4:0] r2, input logic u2,
                       input logic ms, input logic br);
    mem_read_ex = mr; rd_ex = rd; rs1_id = r1; rs1_used_id = u1;
    rs2_id = r2; rs2_used_id = u2; mul_start_ex = ms; branch_taken_ex = br;
    #1;
  endtask

  // Advance one clock edge, return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    arst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("reset", O_DEF, O_DEF);
    chk_cnt("reset", 0, 0, 0);
    tick();
    arst_n = 1'b1;

    drive(1, 5, 5, 1, 0, 0, 0, 0);          // load-use on rs1
    chk_outs("lu_rs1", O_LU, O_LU);
    tick();
    drive(1, 0, 0, 1, 0, 0, 0, 0);          // rd = x0
    chk_outs("x0", O_DEF, O_DEF);
    chk_cnt("lu_rs1", 1, 1, 1);
    tick();
    drive(1, 7, 0, 0, 7, 0, 0, 0);          // rs2 matches but unused
    chk_outs("rs2_unused", O_DEF, O_DEF);
    tick();
    drive(1, 7, 0, 0, 7, 1, 0, 0);          // load-use on rs2
    chk_outs("lu_rs2", O_LU, O_LU);
    tick();
    drive(1, 5, 5, 1, 0, 0, 0, 1);          // branch beats load-use
    chk_outs("br_vs_lu", O_BR, O_BR);
    chk_cnt("lu_rs2", 2, 2, 2);
    tick();
    chk_cnt("br_vs_lu", 2, 2, 2);

    drive(1, 5, 5, 1, 0, 0, 1, 1);          // mul start, branch and load-use ignored
    chk_outs("mul_c0", O_FRZ, O_BR);
    tick();
    drive(1, 5, 5, 1, 0, 0, 0, 1);          // busy: branch/load-use ignored
    chk_outs("mul_c1", O_FRZ, O_BR);
    chk_cnt("mul_c0", 3, 3, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("mul_c2", O_FRZ, O_DEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0);          // release cycle: new start ignored
    chk_outs("mul_c3", O_REL, O_DEF);
    chk_cnt("mul_c2", 5, 5, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("mul_done", O_DEF, O_DEF);
    chk_cnt("mul_done", 5, 5, 2);

    drive(0, 0, 0, 0, 0, 0, 1, 0);          // start a multiply, reset in cycle 1
    chk_outs("mr_c0", O_FRZ, O_DEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("mr_c1", O_FRZ, O_DEF);
    chk_cnt("mr_c1", 6, 6, 2);
    arst_n = 1'b0;
    #1;
    chk_outs("mr_rst", O_DEF, O_DEF);
    chk_cnt("mr_rst", 0, 0, 0);
    tick();
    arst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_outs("mr_idle", O_DEF, O_DEF);
    tick();
    drive(1, 9, 9, 1, 0, 0, 0, 0);          // load-use honoured only in IDLE
    chk_outs("mr_lu", O_LU, O_LU);
    tick();
    chk_cnt("mr_lu", 1, 1, 1);

    for (int i = 0; i < 20; i++) begin
      drive(1, 3, 0, 0, 3, 1, 0, 0);
      tick();
    end
    chk_cnt("sat", 21, 15, 21);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_cnt("sat_hold", 21, 15, 21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
